// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function used by the 4-port mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  // Returns {any, idx}: the first valid port after 'last', wrapping modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input req_idx_t last);
    logic     found;
    req_idx_t idx;
    req_idx_t cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last + req_idx_t'(k);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 data multiplexer shared by all requesters.
module mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin priority encoder over four request lines.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [3:0] valid_i,
  input  logic [1:0] last_i,
  output logic       any_o,
  output logic [1:0] idx_o
);

  assign {any_o, idx_o} = rr_pick(valid_i, req_idx_t'(last_i));

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Four producers share one mux into a 1-entry output register, arbitrated round-robin.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1 on that port.
module mux_4_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data [0:3],
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  req_idx_t         out_src_q, out_src_d;
  req_idx_t         last_grant_q, last_grant_d;

  logic             any_req;
  logic [1:0]       gnt_idx;
  logic [WIDTH-1:0] mux_data;
  logic             can_load;
  logic             load;

  rr_pick_4 u_pick (
    .valid_i (req_valid),
    .last_i  (last_grant_q),
    .any_o   (any_req),
    .idx_o   (gnt_idx)
  );

  mux_4_1 #(.WIDTH(WIDTH)) u_mux (
    .d0_i  (req_data[0]),
    .d1_i  (req_data[1]),
    .d2_i  (req_data[2]),
    .d3_i  (req_data[3]),
    .sel_i (gnt_idx),
    .y_o   (mux_data)
  );

  // Draining and loading in the same cycle keeps the register full with no bubble.
  assign can_load = !out_valid_q || out_ready;
  assign load     = can_load && any_req;

  always_comb begin
    req_ready = '0;
    if (rst_n && load) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = mux_data;
      out_src_d    = gnt_idx;
      last_grant_d = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= 2'd3;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for the 4-port round-robin mux arbiter: directed scenarios plus constrained-random traffic.
module tb_mux_4_1_rr_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [WIDTH-1:0] req_data [0:3];
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH+1:0] exp_q [$];   // {src, data} of transfers awaiting consumption
  int               prio [4];    // ports in current priority order, highest first
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  logic [3:0]       last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    for (int k = 0; k < 4; k++) prio[k] = k;
    exp_q.delete();
  endtask

  // One clock cycle: check ready against the model, clock, then check the register.
  task automatic step();
    int         w;
    logic [3:0] er;
    logic [WIDTH+1:0] ent;
    #1;
    w = -1;
    if (rst_n)
      for (int k = 0; k < 4; k++)
        if (w < 0 && req_valid[prio[k]]) w = prio[k];
    er = (rst_n && (!m_valid || out_ready) && w >= 0) ? (4'b0001 << w) : 4'b0000;
    check("req_ready", {28'b0, req_ready}, {28'b0, er});
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_xfer", 1, 0);
      else begin
        ent = exp_q.pop_front();
        check("sb_xfer", {26'b0, out_src, out_data}, {26'b0, ent});
      end
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (er != 4'b0000) begin
      m_valid = 1'b1;
      m_data  = req_data[w];
      m_src   = w;
      for (int k = 0; k < 4; k++) prio[k] = (w + 1 + k) % 4;
      exp_q.push_back({2'(w), req_data[w]});
    end else if (out_ready) m_valid = 1'b0;
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_data", {28'b0, out_data}, {28'b0, m_data});
    check("out_src", {30'b0, out_src}, m_src);
    last_ready = er;
    @(negedge clk);
  endtask

  task automatic drive_all(input logic [3:0] v, input logic rdy);
    req_valid = v;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) req_data[i] = WIDTH'(1 + i);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    last_ready = '0;
    model_reset();
    drive_all(4'b1111, 1'b0);

    // Reset with every requester asking
    do_reset(2);

    // Single port
    req_valid = 4'b0100;
    req_data[2] = 4'hA;
    out_ready = 1'b1;
    step();
    check("single_src", {30'b0, out_src}, 2);
    check("single_data", {28'b0, out_data}, 32'hA);
    req_valid = 4'b0000;
    step();

    // All valid, back-to-back round robin from port 0
    do_reset(1);
    drive_all(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_order", {30'b0, out_src}, i % 4);
      check("rr_data", {28'b0, out_data}, 1 + (i % 4));
    end

    // Backpressure after the first load
    do_reset(1);
    drive_all(4'b1111, 1'b1);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_src", {30'b0, out_src}, 0);
      check("bp_ready", {28'b0, req_ready}, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_resume", {30'b0, out_src}, 1);

    // Fairness with holes starting from last grant 0
    do_reset(1);
    drive_all(4'b0001, 1'b1);
    step();
    req_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("holes", {30'b0, out_src}, (i == 1) ? 0 : 3);
    end

    // Mid-operation reset drops the pending output
    do_reset(1);
    drive_all(4'b0100, 1'b0);
    step();
    req_valid = 4'b0000;
    step();
    check("pre_rst_valid", {31'b0, out_valid}, 1);
    do_reset(1);
    drive_all(4'b1111, 1'b1);
    step();
    check("rst_prio", {30'b0, out_src}, 0);

    // Random traffic obeying the hold-until-ready rule
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if (last_ready[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_data[i]  = WIDTH'($urandom);
        end
      out_ready = ($urandom_range(0, 99) < 65);
      rst_n     = ($urandom_range(0, 99) >= 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
